descpt_feeder: RTL and testbench
================================

Name: descpt_feeder

Overview:
- Responder end of the matcher's image-descriptor handshake.
- On each `descriptor_request` it reads the next group of 4 image descriptors (row/col/descriptor words) from the image keypoint memory, which is synchronous-read with 1-cycle latency.
- It presents the 4 words on `image_R_C_D_0..3` and pulses `descriptor_valid`.
- It sits between the keypoint/descriptor memory and the match engine, and holds each group stable until the next request is served.

Parameters:
- DESC_W, 403: width of one row/col/descriptor word. Bits [383:0] are the descriptor; bits [DESC_W-1:384] are row/col.
- ADDR_W, 11: image memory address width (keypoint index).
- GRP_W, 10: group counter width. Must hold ceil(2^ADDR_W/4).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse. Latches kpt_num and rewinds to group 0.
- kpt_num  in  11  number of image keypoints stored at addresses 0..kpt_num-1.
- descriptor_request  in  1  level request from the matcher, held until descriptor_valid is seen.
- descriptor_valid  out  1  one-cycle pulse: image_R_C_D_0..3 now carry the requested group.
- image_R_C_D_0  out  DESC_W  lane 0 (keypoint 4g).
- image_R_C_D_1  out  DESC_W  lane 1 (keypoint 4g+1).
- image_R_C_D_2  out  DESC_W  lane 2 (keypoint 4g+2).
- image_R_C_D_3  out  DESC_W  lane 3 (keypoint 4g+3).
- mem_addr  out  ADDR_W  image memory read address.
- mem_re  out  1  image memory read enable.
- mem_dout  in  DESC_W  image memory read data, valid the cycle after mem_re.
- group_idx  out  GRP_W  index of the group most recently delivered.
- busy  out  1  high in FETCH/DRAIN.
- overrun  out  1  sticky: a request arrived after the last group was served.

Behaviour:
- Reset: all outputs and registers clear to 0. State goes to IDLE. Reset asserted mid-fetch aborts immediately; no valid pulse follows.
- States:
  - IDLE: leaves on start.
  - WAIT_REQ.
  - FETCH: 4 cycles.
  - DRAIN: 1 cycle.
  - PULSE: 1 cycle, then WAIT_REQ.
- start:
  - Accepted in IDLE or WAIT_REQ; ignored in FETCH/DRAIN/PULSE.
  - Latches kpt_num. Sets next_grp=0 and n_grp = kpt_num>>2. Clears overrun. Moves to WAIT_REQ.
- Request detection: only a rising edge of descriptor_request (registered previous value 0, current 1) in WAIT_REQ is accepted. This ensures a request still high during the PULSE cycle is never served twice.
- Latency: request first high in cycle 0.
  - Cycles 1-4: mem_re=1, mem_addr = 4*next_grp + k (k=0..3).
  - Lanes 0-2 are captured into staging at the ends of cycles 2-4.
  - At the end of cycle 5, outputs load from staging lanes 0-2 plus mem_dout for lane 3.
  - Cycle 6: descriptor_valid=1 and group_idx=next_grp. next_grp increments at the end of cycle 6.
  - Request-to-valid latency is 6 cycles.
- Stability: image_R_C_D_* and group_idx change only at the DRAIN→PULSE edge, and are held otherwise (including in IDLE after a new start).
- mem_re=0 outside FETCH. mem_addr holds its last value.
- Exhaustion:
  - A request with next_grp >= n_grp sets overrun=1.
  - The block still completes FETCH/DRAIN/PULSE with mem_re suppressed, and all lanes are driven with the pad word, so the matcher never deadlocks. next_grp does not increment.
- Pad word: row/col bits 0, descriptor bits all 1.
- kpt_num=0: n_grp=0, so every request is an overrun with pad output.
- Address arithmetic is done in ADDR_W+2 bits. Addresses are never wrapped; exhaustion is checked first.

Optional Feature:
- Macro: DESCPT_FEEDER_PARTIAL_EN.
- Defined:
  - n_grp = (kpt_num+3)>>2.
  - In the last group, lanes with index 4g+k >= kpt_num are not read (mem_re=0 that cycle) and carry the pad word.
- Undefined:
  - n_grp = kpt_num>>2. The remainder keypoints are never served, matching the match engine's group count.

Test Plan:
- Reset then start with kpt_num=8; memory word at addr i = i.
  - Request rising in cycle 0 -> mem_re cycles 1-4 with addr 0,1,2,3; valid pulse in cycle 6; lanes = 0,1,2,3; group_idx=0.
- Hold descriptor_request high 3 cycles past the valid pulse -> no second fetch.
  - Then drop it, raise it again -> addresses 4..7 are read; group_idx=1.
- kpt_num=8, third request -> overrun=1; lanes = pad word; mem_re stays 0; valid still pulses at cycle 6.
- kpt_num=10 with DESCPT_FEEDER_PARTIAL_EN -> third group reads addr 8,9 only; lanes 2,3 = pad; overrun=0.
  - The same stimulus without the macro gives overrun=1.
- Assert rst_n=0 in cycle 3 of a fetch -> all outputs 0 asynchronously and no valid pulse.
  - After release, start plus a request serves group 0 normally.
- start pulsed in FETCH -> ignored; the current group completes.
  - A start in WAIT_REQ rewinds: the next request reads addr 0..3.

Source files
------------

// File: rtl/descpt_feeder.sv
// descpt_feeder: responder end of the matcher's image-descriptor handshake.
// Each rising edge of descriptor_request fetches the next group of four
// row/col/descriptor words from a 1-cycle-latency synchronous image memory.
// The group is presented on image_R_C_D_0..3 with a one-cycle
// descriptor_valid pulse, and is held until the next request is served.
//
// Optional feature (macro DESCPT_FEEDER_PARTIAL_EN): serve a trailing partial
// group, padding the lanes that lie beyond kpt_num.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, kpt_num      rewind to group 0 and latch the keypoint count
//   descriptor_request  level request from the matcher
//   descriptor_valid    one-cycle pulse: lanes carry the requested group
//   image_R_C_D_0..3    output lanes (keypoints 4g..4g+3)
//   mem_addr, mem_re    image memory read port
//   mem_dout            image memory read data (valid the cycle after mem_re)
//   group_idx           index of the group most recently delivered
//   busy                high while fetching or draining
//   overrun             sticky: a request arrived after the last group
module descpt_feeder #(
  parameter int DESC_W = 403,
  parameter int ADDR_W = 11,
  parameter int GRP_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] kpt_num,
  input  logic              descriptor_request,
  output logic              descriptor_valid,
  output logic [DESC_W-1:0] image_R_C_D_0,
  output logic [DESC_W-1:0] image_R_C_D_1,
  output logic [DESC_W-1:0] image_R_C_D_2,
  output logic [DESC_W-1:0] image_R_C_D_3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [DESC_W-1:0] mem_dout,
  output logic [GRP_W-1:0]  group_idx,
  output logic              busy,
  output logic              overrun
);

  // Pad word: row/col zero, descriptor all ones.
  localparam logic [DESC_W-1:0] PAD = {{(DESC_W-384){1'b0}}, {384{1'b1}}};
  localparam int AW2 = ADDR_W + 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_REQ,
    FETCH,
    DRAIN,
    PULSE
  } state_t;

  state_t             state, state_nxt;
  logic               req_q;
  logic [ADDR_W-1:0]  kpt_lat;
  logic [GRP_W-1:0]   n_grp;
  logic [GRP_W-1:0]   next_grp;
  logic               ovr_cur;
  logic [1:0]         k;
  logic [DESC_W-1:0]  stage0, stage1, stage2;

  logic               req_rise;
  logic               start_ok;
  logic               accept;
  logic               exhausted;
  logic [AW2-1:0]     base;
  logic [3:0]         lane_ok;
  logic [3:0]         fetch_ok;
  logic [GRP_W-1:0]   n_grp_new;

  always_comb begin
    req_rise  = descriptor_request & ~req_q;
    start_ok  = start && (state == IDLE || state == WAIT_REQ);
    // start takes priority over a simultaneous request edge in WAIT_REQ.
    accept    = (state == WAIT_REQ) && !start && req_rise;
    exhausted = (next_grp >= n_grp);
    base      = AW2'(next_grp) << 2;

`ifdef DESCPT_FEEDER_PARTIAL_EN
    n_grp_new = GRP_W'((AW2'(kpt_num) + AW2'(3)) >> 2);
    for (int unsigned i = 0; i < 4; i++) begin
      lane_ok[i] = (base + AW2'(i)) < AW2'(kpt_lat);
    end
`else
    n_grp_new = GRP_W'(kpt_num >> 2);
    lane_ok   = '1;
`endif

    // An exhausted request reads nothing and pads every lane.
    fetch_ok = ovr_cur ? '0 : lane_ok;
  end

  always_comb begin
    state_nxt        = state;
    mem_re           = 1'b0;
    busy             = 1'b0;
    descriptor_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = WAIT_REQ;
      end
      WAIT_REQ: begin
        if (start)         state_nxt = WAIT_REQ;
        else if (req_rise) state_nxt = FETCH;
      end
      FETCH: begin
        busy   = 1'b1;
        mem_re = fetch_ok[k];
        if (k == 2'd3) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = PULSE;
      end
      PULSE: begin
        descriptor_valid = 1'b1;
        state_nxt        = WAIT_REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      req_q          <= 1'b0;
      kpt_lat        <= '0;
      n_grp          <= '0;
      next_grp       <= '0;
      ovr_cur        <= 1'b0;
      overrun        <= 1'b0;
      k              <= '0;
      mem_addr       <= '0;
      stage0         <= '0;
      stage1         <= '0;
      stage2         <= '0;
      image_R_C_D_0  <= '0;
      image_R_C_D_1  <= '0;
      image_R_C_D_2  <= '0;
      image_R_C_D_3  <= '0;
      group_idx      <= '0;
    end else begin
      state <= state_nxt;
      req_q <= descriptor_request;

      if (start_ok) begin
        kpt_lat  <= kpt_num;
        next_grp <= '0;
        n_grp    <= n_grp_new;
        overrun  <= 1'b0;
      end

      if (accept) begin
        ovr_cur <= exhausted;
        k       <= '0;
        if (exhausted) overrun  <= 1'b1;
        else           mem_addr <= base[ADDR_W-1:0];
      end

      if (state == FETCH) begin
        k <= k + 2'd1;
        if (!ovr_cur && k != 2'd3) mem_addr <= mem_addr + ADDR_W'(1);
        // Read data lags the address by one cycle, so step k lands lane k-1.
        case (k)
          2'd1:    stage0 <= fetch_ok[0] ? mem_dout : PAD;
          2'd2:    stage1 <= fetch_ok[1] ? mem_dout : PAD;
          2'd3:    stage2 <= fetch_ok[2] ? mem_dout : PAD;
          default: ;
        endcase
      end

      if (state == DRAIN) begin
        image_R_C_D_0 <= stage0;
        image_R_C_D_1 <= stage1;
        image_R_C_D_2 <= stage2;
        image_R_C_D_3 <= fetch_ok[3] ? mem_dout : PAD;
        group_idx     <= next_grp;
      end

      if (state == PULSE && !ovr_cur) next_grp <= next_grp + GRP_W'(1);
    end
  end

endmodule

// File: tb/tb_descpt_feeder.sv
// Testbench for descpt_feeder: a behavioural memory plus a group-level
// reference model (keypoint count -> group count -> expected lanes and reads).
module tb_descpt_feeder;

  localparam int DESC_W = 403;
  localparam int ADDR_W = 11;
  localparam int GRP_W  = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] kpt_num;
  logic              descriptor_request;
  logic              descriptor_valid;
  logic [DESC_W-1:0] image_R_C_D_0, image_R_C_D_1, image_R_C_D_2, image_R_C_D_3;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [DESC_W-1:0] mem_dout = '0;
  logic [GRP_W-1:0]  group_idx;
  logic              busy;
  logic              overrun;

  descpt_feeder #(.DESC_W(DESC_W), .ADDR_W(ADDR_W), .GRP_W(GRP_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .kpt_num            (kpt_num),
    .descriptor_request (descriptor_request),
    .descriptor_valid   (descriptor_valid),
    .image_R_C_D_0      (image_R_C_D_0),
    .image_R_C_D_1      (image_R_C_D_1),
    .image_R_C_D_2      (image_R_C_D_2),
    .image_R_C_D_3      (image_R_C_D_3),
    .mem_addr           (mem_addr),
    .mem_re             (mem_re),
    .mem_dout           (mem_dout),
    .group_idx          (group_idx),
    .busy               (busy),
    .overrun            (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DESC_W-1:0] word(input int unsigned a);
    logic [31:0] h;
    h = (a * 32'h9E3779B1) ^ 32'h1234_5678;
    return {19'(a + 19'h100), {12{h}}};
  endfunction

  localparam logic [DESC_W-1:0] PADW = {19'd0, {384{1'b1}}};

  // Memory: synchronous read, one cycle of latency.
  always @(posedge clk) if (mem_re) mem_dout <= word(32'(mem_addr));

  // Monitors.
  int unsigned reads[$];
  int vcount = 0;
  always @(negedge clk) begin
    if (rst_n && mem_re) reads.push_back(32'(mem_addr));
    if (descriptor_valid) vcount++;
  end

  // Reference model state.
  int kpt_m = 0, ngrp_m = 0, g_m = 0;
  logic ovr_m = 1'b0;

  function automatic logic [DESC_W-1:0] exp_lane(input int g, input int k);
    int a;
    a = 4 * g + k;
    if (g >= ngrp_m) return PADW;
`ifdef DESCPT_FEEDER_PARTIAL_EN
    if (a >= kpt_m) return PADW;
`endif
    return word(a);
  endfunction

  task automatic do_start(input int n);
    @(posedge clk); #1;
    start = 1'b1; kpt_num = ADDR_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    kpt_m = n; g_m = 0; ovr_m = 1'b0;
`ifdef DESCPT_FEEDER_PARTIAL_EN
    ngrp_m = (n + 3) / 4;
`else
    ngrp_m = n / 4;
`endif
  endtask

  // One request/response. inj_start pulses start (junk kpt_num) mid-fetch.
  task automatic serve(input int hold, input bit inj_start);
    int lat;
    int v0;
    bit found;
    int unsigned expr[$];
    logic [DESC_W-1:0] el[4];
    reads.delete();
    v0 = vcount;
    expr.delete();
    if (g_m < ngrp_m) begin
      for (int k = 0; k < 4; k++) begin
`ifdef DESCPT_FEEDER_PARTIAL_EN
        if (4 * g_m + k < kpt_m) expr.push_back(4 * g_m + k);
`else
        expr.push_back(4 * g_m + k);
`endif
      end
    end else begin
      ovr_m = 1'b1;
    end
    for (int k = 0; k < 4; k++) el[k] = exp_lane(g_m, k);

    @(posedge clk); #1;
    descriptor_request = 1'b1;
    found = 1'b0;
    lat = -1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (inj_start && i == 2) begin start = 1'b1; kpt_num = 11'd3; end
      if (inj_start && i == 3) start = 1'b0;
      if (i == 2) check("busy_fetch", busy, 1'b1);
      if (descriptor_valid) begin found = 1'b1; lat = i; end
    end
    start = 1'b0;
    kpt_num = ADDR_W'(kpt_m);
    check("latency", lat, 6);
    check("lane0", image_R_C_D_0, el[0]);
    check("lane1", image_R_C_D_1, el[1]);
    check("lane2", image_R_C_D_2, el[2]);
    check("lane3", image_R_C_D_3, el[3]);
    check("group_idx", group_idx, g_m);
    check("overrun", overrun, ovr_m);
    check("n_reads", reads.size(), expr.size());
    for (int i = 0; i < expr.size() && i < reads.size(); i++)
      check("read_addr", reads[i], expr[i]);

    // Hold the request past the pulse: must not be served again.
    repeat (hold) @(posedge clk);
    #1 descriptor_request = 1'b0;
    repeat (2) @(negedge clk);
    check("single_valid", vcount - v0, 1);
    check("no_refetch", reads.size(), expr.size());
    check("hold_lane3", image_R_C_D_3, el[3]);
    if (g_m < ngrp_m) g_m++;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; kpt_num = '0; descriptor_request = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", descriptor_valid, 1'b0);
    check("rst_lane0", image_R_C_D_0, '0);
    check("rst_group", group_idx, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_mem_re", mem_re, 1'b0);
    rst_n = 1'b1;

    // kpt_num=8: two full groups, then an overrun.
    do_start(8);
    serve(3, 1'b0);
    serve(1, 1'b0);
    serve(0, 1'b0);

    // kpt_num=10: third group is partial or an overrun depending on build.
    do_start(10);
    serve(0, 1'b0);
    serve(2, 1'b0);
    serve(0, 1'b0);

    // kpt_num=0: every request overruns.
    do_start(0);
    serve(0, 1'b0);

    // Reset in cycle 3 of a fetch.
    do_start(8);
    begin
      int v0;
      v0 = vcount;
      @(posedge clk); #1 descriptor_request = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 1'b0);
      check("arst_mem_re", mem_re, 1'b0);
      check("arst_addr", mem_addr, '0);
      check("arst_lane3", image_R_C_D_3, '0);
      descriptor_request = 1'b0;
      repeat (8) @(negedge clk);
      check("arst_no_valid", vcount - v0, 0);
      @(posedge clk); #1 rst_n = 1'b1;
    end
    do_start(8);
    serve(0, 1'b0);

    // start during FETCH is ignored; start in WAIT_REQ rewinds.
    do_start(12);
    serve(0, 1'b0);
    serve(0, 1'b1);
    serve(0, 1'b0);
    do_start(12);
    serve(0, 1'b0);

    // Randomized sessions.
    for (int it = 0; it < 8; it++) begin
      int nreq;
      do_start($urandom_range(0, 22));
      nreq = $urandom_range(1, ngrp_m + 2);
      if (nreq > 8) nreq = 8;
      for (int r = 0; r < nreq; r++) serve($urandom_range(0, 3), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
